// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipe_register stage chain.
package pipe_pkg;

    localparam int unsigned MAX_DEPTH = 64;
    localparam int unsigned MAX_WIDTH = 1024;

    // Handshake record of the two pipe ports for one cycle.
    typedef struct packed {
        logic in_xfer;
        logic out_xfer;
    } xfer_t;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid bit plus WIDTH data bits, loaded whenever the ready chain allows.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             ready_in,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("pipe_stage: WIDTH out of range");
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            data  <= RESET_DATA;
        end else if (ready_in) begin
            valid <= prev_valid;
            data  <= prev_data;
        end
    end

endmodule

// File: rtl/pipe_register.sv
// Bubble-collapsing valid/ready register pipeline of DEPTH stages with an occupancy count.
module pipe_register
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 3,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int unsigned CW = count_width(DEPTH);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("pipe_register: DEPTH out of range");
    end

    // Index 0 is the input port, index k+1 is the output of stage k.
    logic [DEPTH:0]   chain_v;
    logic [WIDTH-1:0] chain_d [DEPTH+1];
    logic             rdy     [DEPTH];
    xfer_t            xf;

    assign chain_v[0] = in_valid;
    assign chain_d[0] = in_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        // Unrolled form of "empty or downstream ready": stage k can move
        // unless it and every stage after it are full and the sink stalls.
        always_comb begin
            rdy[k] = out_ready || !(&chain_v[DEPTH:k+1]);
        end

        pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .clear      (flush),
            .ready_in   (rdy[k]),
            .prev_valid (chain_v[k]),
            .prev_data  (chain_d[k]),
            .valid      (chain_v[k+1]),
            .data       (chain_d[k+1])
        );
    end

    assign in_ready  = rdy[0] && !flush && !reset;
    assign out_valid = chain_v[DEPTH];
    assign out_data  = chain_d[DEPTH];

    always_comb begin
        xf.in_xfer  = in_valid && in_ready;
        xf.out_xfer = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else begin
            unique case ({xf.in_xfer, xf.out_xfer})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_register.sv
// Scoreboard bench for pipe_register (WIDTH=8, DEPTH=3): directed cases then a random-stall run.
module tb_pipe_register;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 3;
    localparam logic [7:0]  RST_D = 8'hC3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] count;

    int         ncmp = 0;
    int         nfail = 0;
    bit         mon_on = 1'b0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    pipe_register #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RESET_DATA (RST_D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Words accepted at the input are queued; the handshake that will happen at
    // the next posedge is observed mid-cycle, when inputs and state are settled.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("count", 32'(count), sb.size());
            if (reset) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        ncmp++;
                        nfail++;
                        $display("FAIL sb_pop: got 0x%0h, required no word at %0t", out_data, $time);
                    end else begin
                        chk("sb_data", 32'(out_data), 32'(sb.pop_front()));
                    end
                end
                if (flush) sb.delete();
                else if (in_valid && in_ready) sb.push_back(in_data);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'(RST_D));
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        tick();
        reset = 1'b0;
        mon_on = 1'b1;

        // Single word latency
        do_reset();
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        #1;
        chk("lat_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("lat_count", 32'(count), (c <= 3) ? 32'd1 : 32'd0);
            chk("lat_out_valid", 32'(out_valid), (c == 3) ? 32'd1 : 32'd0);
            if (c == 3) chk("lat_out_data", 32'(out_data), 32'h11);
            tick();
        end

        // Back-to-back stream
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            in_valid = (c < 10);
            in_data  = 8'(c + 1);
            #1;
            if (c < 10) chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (c >= 3) begin
                chk("stream_out_valid", 32'(out_valid), 32'd1);
                chk("stream_out_data", 32'(out_data), 32'(c - 2));
            end
            tick();
        end
        in_valid = 1'b0;

        // Fill while stalled, hold, then simultaneous in/out at full
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            #1;
            chk("fill_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_data = 8'hA3;
        for (int h = 0; h < 2; h++) begin
            #1;
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("full_count", 32'(count), 32'd3);
            chk("full_out_valid", 32'(out_valid), 32'd1);
            chk("full_out_data", 32'(out_data), 32'hA0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("full_pass_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("full_pass_count", 32'(count), 32'd3);
        chk("full_pass_out_data", 32'(out_data), 32'hA1);
        repeat (4) tick();
        chk("drain_count", 32'(count), 32'd0);

        // Flush with a concurrent input word
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h21 + i);
            tick();
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_count_pre", 32'(count), 32'd2);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'(RST_D));
        out_ready = 1'b1;
        repeat (5) begin
            tick();
            chk("flush_quiet", 32'(out_valid), 32'd0);
        end

        // Reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h30 + i);
            tick();
        end
        #1;
        chk("mid_count_pre", 32'(count), 32'd3);
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'(RST_D));

        // Random stalls with occasional flush and reset
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 199) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        chk("final_count", 32'(count), 32'd0);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
